// File: rtl/seq_mult_ctrl.sv
// Control FSM for a shift-add sequential multiplier: sequences load, per-bit
// add-test and shift, owns the iteration counter, start/done handshake and abort.
module seq_mult_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             abort,
  input  logic             q0,
  output logic             ld_a,
  output logic             ld_b,
  output logic             clr_p,
  output logic             add_en,
  output logic             shift,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CALC  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    clr_p   = 1'b0;
    add_en  = 1'b0;
    shift   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        ld_a    = 1'b1;
        ld_b    = 1'b1;
        clr_p   = 1'b1;
        busy    = 1'b1;
        cnt_d   = CNT_W'(WIDTH);
        state_d = S_CALC;
      end
      S_CALC: begin
        add_en  = q0;
        busy    = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shift = 1'b1;
        busy  = 1'b1;
        // Exit on cnt==1 so the decrement below can never wrap past zero.
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? S_DONE : S_CALC;
      end
      S_DONE: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides every other transition, but only while working.
    if (abort && (state_q == S_LOAD || state_q == S_CALC || state_q == S_SHIFT)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl with a reference shift-add datapath
// supplying q0 and producing the product.
module tb_seq_mult_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       q0;
  logic       ld_a, ld_b, clr_p, add_en, shift, busy, done;
  logic [2:0] cnt;

  int passed = 0;
  int total  = 0;

  logic [3:0] mcand  = 4'd0;
  logic [3:0] mplier = 4'd0;
  logic       q0_zero = 1'b0;
  logic [3:0] a_reg = 4'd0;
  logic [3:0] b_sh  = 4'd0;
  logic [4:0] acc   = 5'd0;
  logic [7:0] product;

  always #5 clk = ~clk;

  seq_mult_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .abort  (abort),
    .q0     (q0),
    .ld_a   (ld_a),
    .ld_b   (ld_b),
    .clr_p  (clr_p),
    .add_en (add_en),
    .shift  (shift),
    .busy   (busy),
    .done   (done),
    .cnt    (cnt)
  );

  // Reference datapath: {acc, b_sh} forms the product/multiplier pair.
  always @(posedge clk) begin
    if (ld_a)  a_reg <= mcand;
    if (ld_b)  b_sh  <= mplier;
    if (clr_p) acc   <= 5'd0;
    if (add_en) acc  <= acc + {1'b0, a_reg};
    if (shift) begin
      acc  <= {1'b0, acc[4:1]};
      b_sh <= {acc[0], b_sh[3:1]};
    end
  end

  assign q0      = q0_zero ? 1'b0 : b_sh[0];
  assign product = {acc[3:0], b_sh};

  // Strobe exclusivity and add_en==q0 in CALC, every cycle.
  always @(negedge clk) begin
    logic calc;
    calc = busy & ~ld_a & ~shift;
    total++;
    if (((ld_a | ld_b | clr_p) & (add_en | shift)) | (add_en & shift)) begin
      $display("FAIL exclusivity: ld=%b%b%b add_en=%b shift=%b, required no overlap",
               ld_a, ld_b, clr_p, add_en, shift);
    end else passed++;
    total++;
    if (add_en !== (calc & q0)) begin
      $display("FAIL add_en_q0: add_en=%b, required %b (calc=%b q0=%b)",
               add_en, calc & q0, calc, q0);
    end else passed++;
  end

  task automatic test_reset();
    #2 clr = 1'b0;
    #1;
    total++;
    if ({ld_a, ld_b, clr_p, add_en, shift, busy, done, cnt} !== 10'd0) begin
      $display("FAIL reset_state: got %b, required 0", {ld_a, ld_b, clr_p, add_en, shift, busy, done, cnt});
    end else passed++;
    @(negedge clk);
    clr = 1'b1;
    mcand = 4'b0110; mplier = 4'b1011; start = 1'b1;
    @(negedge clk);  // LOAD
    start = 1'b0;
    @(negedge clk);  // CALC, bit0 = 1
    total++;
    if (add_en !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL reset_precalc: add_en=%b busy=%b, required 1 1", add_en, busy);
    end else passed++;
    #2 clr = 1'b0;
    #1;
    total++;
    if ({busy, add_en, shift, done, ld_a, cnt} !== 8'd0) begin
      $display("FAIL reset_midcalc: busy=%b add_en=%b shift=%b done=%b ld_a=%b cnt=%0d, required all 0",
               busy, add_en, shift, done, ld_a, cnt);
    end else passed++;
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({ld_a, ld_b, clr_p, add_en, shift, busy, done, cnt} !== 10'd0) begin
        $display("FAIL reset_idle[%0d]: got %b, required 0", i,
                 {ld_a, ld_b, clr_p, add_en, shift, busy, done, cnt});
      end else passed++;
    end
  endtask

  task automatic test_basic();
    logic [3:0] bits;
    bits = 4'b1011;
    mcand = 4'b0110; mplier = 4'b1011; start = 1'b1;
    @(negedge clk);  // LOAD
    total++;
    if ({ld_a, ld_b, clr_p, busy, add_en, shift, done} !== 7'b1111000 || cnt !== 3'd0) begin
      $display("FAIL basic_load: strobes=%b cnt=%0d, required 1111000 cnt=0",
               {ld_a, ld_b, clr_p, busy, add_en, shift, done}, cnt);
    end else passed++;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);  // CALC
      total++;
      if (add_en !== bits[i] || shift !== 1'b0 || busy !== 1'b1 || cnt !== 3'(4 - i)) begin
        $display("FAIL basic_calc[%0d]: add_en=%b shift=%b busy=%b cnt=%0d, required %b 0 1 %0d",
                 i, add_en, shift, busy, cnt, bits[i], 4 - i);
      end else passed++;
      @(negedge clk);  // SHIFT
      total++;
      if (shift !== 1'b1 || add_en !== 1'b0 || busy !== 1'b1 || cnt !== 3'(4 - i)) begin
        $display("FAIL basic_shift[%0d]: shift=%b add_en=%b busy=%b cnt=%0d, required 1 0 1 %0d",
                 i, shift, add_en, busy, cnt, 4 - i);
      end else passed++;
    end
    @(negedge clk);  // DONE, edge k+9
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || cnt !== 3'd0) begin
      $display("FAIL basic_done: done=%b busy=%b cnt=%0d, required 1 0 0", done, busy, cnt);
    end else passed++;
    total++;
    if (product !== 8'd66) begin
      $display("FAIL basic_product: got %0d, required 66", product);
    end else passed++;
    @(negedge clk);  // IDLE
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL basic_after: done=%b busy=%b, required 0 0", done, busy);
    end else passed++;
  endtask

  task automatic test_zero();
    int busy_cycles, done_at;
    logic add_seen;
    busy_cycles = 0; done_at = -1; add_seen = 1'b0;
    q0_zero = 1'b1;
    mcand = 4'b1111; mplier = 4'b1011; start = 1'b1;
    for (int c = 0; c < 30 && done_at < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cycles++;
      if (add_en) add_seen = 1'b1;
      if (done) done_at = c;
    end
    total++;
    if (done_at !== 9) begin
      $display("FAIL zero_done_at: got %0d, required 9", done_at);
    end else passed++;
    total++;
    if (busy_cycles !== 9) begin
      $display("FAIL zero_busy_cycles: got %0d, required 9", busy_cycles);
    end else passed++;
    total++;
    if (add_seen !== 1'b0) begin
      $display("FAIL zero_add_en: got %b, required 0", add_seen);
    end else passed++;
    @(negedge clk);
    q0_zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    int d_idx[$];
    int exp_idx[4];
    exp_idx = '{9, 20, 31, 42};
    mcand = 4'b0011; mplier = 4'b0101; start = 1'b1;
    for (int c = 0; c < 43; c++) begin
      @(negedge clk);
      if (done) d_idx.push_back(c);
    end
    start = 1'b0;
    total++;
    if (d_idx.size() !== 4) begin
      $display("FAIL b2b_count: got %0d pulses, required 4", d_idx.size());
    end else passed++;
    for (int i = 0; i < 4 && i < d_idx.size(); i++) begin
      total++;
      if (d_idx[i] !== exp_idx[i]) begin
        $display("FAIL b2b_pulse[%0d]: at %0d, required %0d", i, d_idx[i], exp_idx[i]);
      end else passed++;
    end
    total++;
    if (product !== 8'd15) begin
      $display("FAIL b2b_product: got %0d, required 15", product);
    end else passed++;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || ld_a !== 1'b0) begin
      $display("FAIL b2b_no_queue: busy=%b ld_a=%b, required 0 0", busy, ld_a);
    end else passed++;
  endtask

  task automatic test_abort();
    int n_done, n_busy, done_at;
    logic [7:0] prod_at_done;
    n_done = 0; n_busy = 0; done_at = -1; prod_at_done = 8'd0;
    mcand = 4'b0110; mplier = 4'b1011; start = 1'b1;
    @(negedge clk);  // LOAD
    start = 1'b0;
    @(negedge clk);  // CALC
    @(negedge clk);  // SHIFT 1
    @(negedge clk);  // CALC
    @(negedge clk);  // SHIFT 2
    total++;
    if (shift !== 1'b1 || cnt !== 3'd3) begin
      $display("FAIL abort_pre: shift=%b cnt=%0d, required 1 3", shift, cnt);
    end else passed++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({busy, shift, add_en, ld_a, done} !== 5'd0 || cnt !== 3'd0) begin
      $display("FAIL abort_idle: busy=%b shift=%b add_en=%b ld_a=%b done=%b cnt=%0d, required all 0",
               busy, shift, add_en, ld_a, done, cnt);
    end else passed++;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
    end
    total++;
    if (n_done !== 0 || n_busy !== 0) begin
      $display("FAIL abort_quiet: done pulses=%0d busy cycles=%0d, required 0 0", n_done, n_busy);
    end else passed++;
    // abort is ignored in IDLE, so this start still launches an operation
    mcand = 4'b1111; mplier = 4'b1111; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    total++;
    if (ld_a !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL abort_restart_load: ld_a=%b busy=%b, required 1 1", ld_a, busy);
    end else passed++;
    for (int c = 1; c < 20 && done_at < 0; c++) begin
      @(negedge clk);
      if (done) begin
        done_at = c;
        prod_at_done = product;
      end
    end
    total++;
    if (done_at !== 9) begin
      $display("FAIL abort_restart_done: at %0d, required 9", done_at);
    end else passed++;
    total++;
    if (prod_at_done !== 8'd225) begin
      $display("FAIL abort_restart_product: got %0d, required 225", prod_at_done);
    end else passed++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
- Control unit for the shift-add sequential multiplier.
- Sequences the datapath registers (multiplicand, multiplier/shift, product accumulator) through load, per-bit add-test and shift, then signals completion.
- The datapath returns only the multiplier LSB (q0). This block owns the iteration counter, the start/done handshake and the abort path.

Parameters:
- WIDTH, 4, operand width in bits; equals the number of add/shift iterations.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous, active-low reset; clears all state and outputs immediately.
- start  in  1  level request; sampled only in IDLE.
- abort  in  1  synchronous cancel; honoured in LOAD, CALC and SHIFT.
- q0  in  1  current multiplier LSB from the datapath shift register.
- ld_a  out  1  load multiplicand register.
- ld_b  out  1  load multiplier shift register.
- clr_p  out  1  clear product accumulator.
- add_en  out  1  accumulator adds multiplicand this cycle.
- shift  out  1  shift product/multiplier pair right by one.
- busy  out  1  operation in progress.
- done  out  1  product valid; one-cycle pulse.
- cnt  out  CNT_W  remaining iterations.

Behaviour:
- States: IDLE, LOAD, CALC, SHIFT, DONE. Binary encoding is free; the state is not a port.
- Reset (clr=0, asynchronous): state=IDLE, cnt=0, all control outputs 0.
- IDLE:
  - All strobes 0, busy=0.
  - start=1 at an edge → LOAD; otherwise stay in IDLE.
- LOAD (one cycle):
  - ld_a=ld_b=clr_p=1, busy=1.
  - cnt loads WIDTH at exit.
  - Next state CALC.
- CALC (one cycle):
  - add_en=q0 (combinational, Mealy), busy=1.
  - Next state SHIFT.
- SHIFT (one cycle):
  - shift=1, busy=1, cnt decrements at exit.
  - If cnt==1 on entry → DONE; else → CALC.
- DONE (one cycle):
  - done=1, busy=0, cnt=0.
  - Next state IDLE.
- Strobe exclusivity: ld_a/ld_b/clr_p are never high together with add_en or shift. add_en and shift are never high in the same cycle.
- Latency: if start is sampled at edge k, LOAD spans k..k+1 and done is high for the cycle following edge k+2*WIDTH+1. For WIDTH=4, that is edge k+9.
- start while busy: ignored, with no queuing.
- start held high through DONE: a new operation begins at the edge leaving IDLE, i.e. IDLE lasts exactly one cycle.
- abort=1 at an edge while in LOAD/CALC/SHIFT:
  - Next state is IDLE, cnt=0, and no done pulse.
  - abort has priority over all other transitions.
  - abort in IDLE or DONE is ignored, so DONE still completes.
- Reset asserted mid-operation: outputs drop in the same cycle with no clock required. After release, the block waits in IDLE for start.
- cnt wrap: never decrements below 0. The SHIFT→DONE decision uses cnt==1, so no wrap-around is possible.

Test Plan:
- Reset: clr=0 mid-CALC → same cycle busy=0, add_en=0, shift=0, cnt=0. After release with start=0, the block stays in IDLE for 5 cycles with all outputs 0.
- Basic op, WIDTH=4, q0 driven from a model shift register loaded with 4'b1011:
  - start pulse at edge k → ld_a/ld_b/clr_p high one cycle.
  - add_en high in CALC for bits 0, 1 and 3, low for bit 2.
  - shift high in 4 cycles; cnt sequence 4,3,2,1,0.
  - done high exactly one cycle after edge k+9.
  - With the reference datapath, multiplicand 4'b0110 gives product 8'd66.
- All-zero multiplier (q0=0 always): add_en never asserts; done still at k+9; busy high for exactly 9 cycles.
- start held high continuously: done pulses every 11 cycles (LOAD + 8 + DONE + IDLE). Extra start cycles during busy have no effect.
- abort asserted during the 2nd SHIFT → next cycle IDLE, cnt=0, and no done within the following 20 cycles. A subsequent start yields a normal operation.
- Strobe exclusivity assertion checked every cycle across all scenarios above; add_en must equal q0 whenever the state is CALC.
